softmax_norm: RTL and testbench

//  Final softmax stage, directly downstream of the exp LUT lookup. Buffers one row of N exp

---
 rtl/softmax_norm_if.sv | 35 +++
 rtl/softmax_norm.sv | 198 +++++++++++++++++++
 tb/tb_softmax_norm.sv | 229 ++++++++++++++++++++++
 3 files changed

// File: rtl/softmax_norm_if.sv
// softmax_norm_if: bundles the exp input stream and the probability output stream.
// Latency: none (wires only).
// Backpressure: exp_ready stalls the producer; out_ready stalls the normaliser.
//
// Signals
//   exp_valid / exp / exp_ready              exp values from the LUT stage
//   out_valid / out_prob / out_idx / out_ready  normalised probability stream
//   row_done                                  1-cycle pulse after a row's last output
//   sum_zero_err                              sticky "row summed to zero" flag
// Modports: master = producer/consumer side, slave = softmax_norm side.
interface softmax_norm_if #(
   parameter int N     = 16,
   parameter int EXP_W = 32,
   parameter int OUT_W = 8
);
   logic                 exp_valid;
   logic [EXP_W-1:0]     exp;
   logic                 exp_ready;
   logic                 out_valid;
   logic                 out_ready;
   logic [OUT_W-1:0]     out_prob;
   logic [$clog2(N)-1:0] out_idx;
   logic                 row_done;
   logic                 sum_zero_err;

   modport master (
      output exp_valid, exp, out_ready,
      input  exp_ready, out_valid, out_prob, out_idx, row_done, sum_zero_err
   );

   modport slave (
      input  exp_valid, exp, out_ready,
      output exp_ready, out_valid, out_prob, out_idx, row_done, sum_zero_err
   );
endinterface

// File: rtl/softmax_norm.sv
// softmax_norm: buffers a row of N exp values, sums them, then divides each by the sum.
// Latency: out_valid rises OUT_W+2 cycles after the last accept and after each output handshake.
// Backpressure: exp_ready=0 from the row's last accept until the row's last output is taken;
//   out_prob/out_idx hold while out_valid=1 and out_ready=0.
//
// Ports
//   clk, reset   clock (rising edge) and synchronous active-high reset
//   io (slave)   exp input stream, probability output stream, row_done, sum_zero_err
// Optional feature: define SOFTMAX_ROUND_EN for round-half-up division (bias sum/2 added
//   to the dividend in the load cycle); undefined gives truncating division.
module softmax_norm #(
   parameter int N     = 16,
   parameter int EXP_W = 32,
   parameter int OUT_W = 8
) (
   input  logic          clk,
   input  logic          reset,
   softmax_norm_if.slave io
);

   localparam int SUM_W  = EXP_W + $clog2(N);
   localparam int IDX_W  = $clog2(N);
   localparam int DVD_W  = SUM_W + OUT_W + 1;
   localparam int STEP_W = $clog2(OUT_W + 2);

   localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(N - 1);
   localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(OUT_W + 1);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_ACC,
      ST_DIV,
      ST_OUT
   } state_t;

   state_t             state;
   state_t             state_nxt;

   logic [EXP_W-1:0]   row_buf [N];
   logic [SUM_W-1:0]   sum_q;
   logic [IDX_W-1:0]   cnt;
   logic [IDX_W-1:0]   idx;
   logic [STEP_W-1:0]  step;        // 0 = load cycle, 1..OUT_W+1 = quotient bits
   logic [SUM_W-1:0]   rem_q;       // partial remainder, always < sum between steps
   logic [OUT_W:0]     low_q;       // dividend bits still to be shifted in, MSB first
   logic [OUT_W-1:0]   quo_q;       // quotient bits produced so far
   logic [OUT_W-1:0]   prob_q;
   logic               row_done_q;
   logic               err_q;

   logic               exp_ready_int;
   logic               accept;
   logic               out_hs;

   // divider datapath
   logic [SUM_W-1:0]   bias;
   logic [DVD_W-1:0]   dvd;
   logic [SUM_W:0]     trial;
   logic               ge;
   logic [SUM_W-1:0]   rem_nxt;
   logic [OUT_W:0]     q_full;
   logic [OUT_W-1:0]   q_sat;

   assign exp_ready_int = (state == ST_IDLE) || (state == ST_ACC);
   assign accept        = io.exp_valid && exp_ready_int;
   assign out_hs        = (state == ST_OUT) && io.out_ready;

   assign io.exp_ready    = exp_ready_int;
   assign io.out_valid    = (state == ST_OUT);
   assign io.out_prob     = prob_q;
   assign io.out_idx      = idx;
   assign io.row_done     = row_done_q;
   assign io.sum_zero_err = err_q;

   // Because every entry is part of the sum, the quotient never exceeds 2^OUT_W, so only
   // the low OUT_W+1 quotient bits can be non-zero. The partial remainder reached after
   // the leading (zero) quotient bits is simply dvd >> (OUT_W+1); the load cycle starts
   // there, and the OUT_W+1 iterations then finish the long division exactly.
   always_comb begin
`ifdef SOFTMAX_ROUND_EN
      bias = sum_q >> 1;
`else
      bias = '0;
`endif
      dvd     = (DVD_W'(row_buf[idx]) << OUT_W) + DVD_W'(bias);
      trial   = {rem_q, low_q[OUT_W]};
      ge      = (trial >= {1'b0, sum_q});
      rem_nxt = ge ? SUM_W'(trial - {1'b0, sum_q}) : trial[SUM_W-1:0];
      q_full  = {quo_q, ge};
      // A zero sum makes every trial subtraction succeed; force the result to 0 instead.
      if (sum_q == '0) begin
         q_sat = '0;
      end else if (q_full[OUT_W]) begin
         q_sat = '1;
      end else begin
         q_sat = q_full[OUT_W-1:0];
      end
   end

   // state register
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // next-state logic
   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE: if (accept) state_nxt = ST_ACC;
         ST_ACC:  if (accept && (cnt == LAST_IDX)) state_nxt = ST_DIV;
         ST_DIV:  if (step == LAST_STEP) state_nxt = ST_OUT;
         ST_OUT: begin
            if (out_hs) begin
               state_nxt = (idx == LAST_IDX) ? ST_IDLE : ST_DIV;
            end
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   // row buffer: written at the running count, never read while being filled
   always_ff @(posedge clk) begin
      if (accept && !reset) begin
         row_buf[cnt] <= io.exp;
      end
   end

   // accumulator, counters, divider and output registers
   always_ff @(posedge clk) begin
      if (reset) begin
         sum_q      <= '0;
         cnt        <= '0;
         idx        <= '0;
         step       <= '0;
         rem_q      <= '0;
         low_q      <= '0;
         quo_q      <= '0;
         prob_q     <= '0;
         row_done_q <= 1'b0;
         err_q      <= 1'b0;
      end else begin
         row_done_q <= 1'b0;
         case (state)
            ST_IDLE, ST_ACC: begin
               if (accept) begin
                  cnt <= cnt + 1'b1;   // wraps to 0 as the row fills
                  if (state == ST_IDLE) begin
                     sum_q <= SUM_W'(io.exp);
                     err_q <= 1'b0;
                  end else begin
                     sum_q <= sum_q + SUM_W'(io.exp);
                  end
                  if ((state == ST_ACC) && (cnt == LAST_IDX)) begin
                     idx  <= '0;
                     step <= '0;
                  end
               end
            end
            ST_DIV: begin
               if (step == '0) begin
                  rem_q <= dvd[DVD_W-1:OUT_W+1];
                  low_q <= dvd[OUT_W:0];
                  quo_q <= '0;
                  if (sum_q == '0) err_q <= 1'b1;
                  step  <= step + 1'b1;
               end else begin
                  rem_q <= rem_nxt;
                  low_q <= {low_q[OUT_W-1:0], 1'b0};
                  quo_q <= q_full[OUT_W-1:0];
                  if (step == LAST_STEP) begin
                     prob_q <= q_sat;
                     step   <= '0;
                  end else begin
                     step <= step + 1'b1;
                  end
               end
            end
            ST_OUT: begin
               if (out_hs) begin
                  step <= '0;
                  if (idx == LAST_IDX) begin
                     idx        <= '0;
                     row_done_q <= 1'b1;
                  end else begin
                     idx <= idx + 1'b1;
                  end
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_softmax_norm.sv
// tb_softmax_norm: randomized and directed rows checked against an arithmetic softmax model.
// Latency: checks first-output latency and whole-row time when out_ready is held high.
// Backpressure: random out_ready, held stalls, and exp_valid noise while the block is busy.
module tb_softmax_norm;

   localparam int N     = 16;
   localparam int EXP_W = 32;
   localparam int OUT_W = 8;
   localparam int IDX_W = $clog2(N);
   localparam int LAT   = OUT_W + 3;   // negedges from last accept to first out_valid

`ifdef SOFTMAX_ROUND_EN
   localparam int T5_IDX0 = 43;
`else
   localparam int T5_IDX0 = 42;
`endif

   typedef logic [EXP_W-1:0] row_t [N];
   typedef logic [OUT_W-1:0] prob_row_t [N];

   bit   clk;
   logic reset;
   int   total = 0;
   int   bad   = 0;

   softmax_norm_if #(.N(N), .EXP_W(EXP_W), .OUT_W(OUT_W)) io ();

   softmax_norm #(.N(N), .EXP_W(EXP_W), .OUT_W(OUT_W)) dut (
      .clk   (clk),
      .reset (reset),
      .io    (io)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
      total++;
      if (got !== want) begin
         bad++;
         $display("FAIL %s: got %0d, want %0d", tag, got, want);
      end
   endtask

   // prob = entry / sum as a Q0.OUT_W fraction, saturated; zero sum gives 0
   function automatic logic [OUT_W-1:0] ref_prob(input longint unsigned e,
                                                 input longint unsigned s);
      longint unsigned q;
      if (s == 0) return '0;
`ifdef SOFTMAX_ROUND_EN
      q = (e * (64'd1 << OUT_W) + s / 2) / s;
`else
      q = (e * (64'd1 << OUT_W)) / s;
`endif
      if (q > (64'd1 << OUT_W) - 1) q = (64'd1 << OUT_W) - 1;
      return q[OUT_W-1:0];
   endfunction

   task automatic feed_row(input row_t v, input bit gaps, output logic err_first);
      int i = 0, guard = 0, rdy_bad = 0;
      bit seen = 1'b0;
      err_first = 1'b0;
      while (i < N && guard < 1000) begin
         @(negedge clk);
         guard++;
         if (i == 1 && !seen) begin
            err_first = io.sum_zero_err;
            seen = 1'b1;
         end
         if (io.exp_ready !== 1'b1) rdy_bad++;
         if (gaps && $urandom_range(3) == 0) begin
            io.exp_valid = 1'b0;
         end else begin
            io.exp_valid = 1'b1;
            io.exp = v[i];
            i++;
         end
      end
      check("feed_count", i, N);
      check("feed_exp_ready", rdy_bad, 0);
   endtask

   task automatic collect_row(input row_t v, input int rdy_pct, input int hold_idx,
                              input int stop_at, output prob_row_t obs);
      longint unsigned s = 0;
      int got = 0, guard = 0, first_vld = -1, last_hs = -1;
      int held = 0, hold_bad = 0, rdy_bad = 0, rd_early = 0;
      for (int i = 0; i < N; i++) s += v[i];
      for (int i = 0; i < N; i++) obs[i] = '0;
      while (got < stop_at && guard < 3000) begin
         @(negedge clk);
         guard++;
         io.exp_valid = 1'($urandom_range(1));
         io.exp = $urandom;
         if (io.exp_ready !== 1'b0) rdy_bad++;
         if (io.row_done !== 1'b0) rd_early++;
         if (io.out_valid === 1'b1 && first_vld < 0) first_vld = guard;
         if (io.out_valid === 1'b1 && got == hold_idx && held < 5) begin
            io.out_ready = 1'b0;
            held++;
            if (io.out_prob !== ref_prob(v[got], s) || io.out_idx !== IDX_W'(got)) hold_bad++;
         end else begin
            io.out_ready = ($urandom_range(99) < rdy_pct);
            if (io.out_valid === 1'b1 && io.out_ready) begin
               obs[got] = io.out_prob;
               check("prob", io.out_prob, ref_prob(v[got], s));
               check("idx", io.out_idx, got);
               got++;
               last_hs = guard;
            end
         end
      end
      // let the final handshake edge happen before releasing the inputs
      @(negedge clk);
      io.exp_valid = 1'b0;
      io.out_ready = 1'b0;
      check("out_count", got, stop_at);
      check("exp_ready_busy", rdy_bad, 0);
      check("row_done_early", rd_early, 0);
      if (hold_idx >= 0) begin
         check("hold_cycles", held, 5);
         check("hold_stable", hold_bad, 0);
      end
      if (rdy_pct == 100 && hold_idx < 0) begin
         check("first_latency", first_vld, LAT);
         if (stop_at == N) check("row_time", last_hs, N * LAT);
      end
      if (stop_at == N) begin
         check("row_done_pulse", io.row_done, 1);
         check("idle_exp_ready", io.exp_ready, 1);
         check("idle_out_valid", io.out_valid, 0);
         check("sum_zero_err", io.sum_zero_err, (s == 0));
         @(negedge clk);
         check("row_done_clear", io.row_done, 0);
      end
   endtask

   initial begin
      row_t      v;
      prob_row_t obs;
      logic      ef;

      reset = 1'b1;
      io.exp_valid = 1'b0;
      io.exp = '0;
      io.out_ready = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_exp_ready", io.exp_ready, 1);
      check("rst_out_valid", io.out_valid, 0);
      check("rst_out_prob", io.out_prob, 0);
      check("rst_out_idx", io.out_idx, 0);
      check("rst_row_done", io.row_done, 0);
      check("rst_err", io.sum_zero_err, 0);
      reset = 1'b0;
      @(negedge clk);

      // uniform row, out_ready held high
      for (int i = 0; i < N; i++) v[i] = 32'd1000;
      feed_row(v, 1'b0, ef);
      collect_row(v, 100, -1, N, obs);
      for (int i = 0; i < N; i++) check("uniform", obs[i], 16);

      // one-hot row saturates
      for (int i = 0; i < N; i++) v[i] = '0;
      v[5] = 32'd5000;
      feed_row(v, 1'b0, ef);
      collect_row(v, 60, -1, N, obs);
      check("onehot_sat", obs[5], 255);
      check("onehot_zero", obs[0], 0);

      // zero row: sticky error holds while idle
      for (int i = 0; i < N; i++) v[i] = '0;
      feed_row(v, 1'b0, ef);
      collect_row(v, 100, -1, N, obs);
      repeat (3) @(negedge clk);
      check("err_sticky", io.sum_zero_err, 1);

      // backpressure hold at idx 3; error clears on first accept
      for (int i = 0; i < N; i++) v[i] = $urandom_range(5000);
      feed_row(v, 1'b1, ef);
      check("err_clear_first_accept", ef, 0);
      collect_row(v, 80, 3, N, obs);

      // rounding corner
      for (int i = 0; i < N; i++) v[i] = 32'd1;
      v[0] = 32'd3;
      feed_row(v, 1'b0, ef);
      collect_row(v, 100, -1, N, obs);
      check("round_idx0", obs[0], T5_IDX0);
      check("round_idx1", obs[1], 14);

      // reset while dividing idx 7, then a fresh uniform row
      for (int i = 0; i < N; i++) v[i] = 32'd1000;
      feed_row(v, 1'b0, ef);
      collect_row(v, 100, -1, 7, obs);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      check("midrst_out_valid", io.out_valid, 0);
      check("midrst_exp_ready", io.exp_ready, 1);
      check("midrst_out_idx", io.out_idx, 0);
      feed_row(v, 1'b0, ef);
      collect_row(v, 100, -1, N, obs);
      for (int i = 0; i < N; i++) check("after_reset", obs[i], 16);

      // largest legal entries: sum uses the full accumulator width
      for (int i = 0; i < N; i++) v[i] = 32'hFFFF_FFFF;
      feed_row(v, 1'b0, ef);
      collect_row(v, 100, -1, N, obs);
      check("max_row", obs[N-1], 16);

      // random rows with random gaps and backpressure
      for (int r = 0; r < 9; r++) begin
         for (int i = 0; i < N; i++) begin
            case (r % 3)
               0:       v[i] = $urandom_range(1000);
               1:       v[i] = $urandom;
               default: v[i] = ($urandom_range(3) == 0) ? $urandom_range(1 << 20, 1) : 32'd0;
            endcase
         end
         feed_row(v, 1'b1, ef);
         collect_row(v, $urandom_range(100, 30), ((r % 4) == 0) ? $urandom_range(N - 1) : -1,
                     N, obs);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
